// File: rtl/seg_scan_decoder_pkg.sv
// Shared seven-segment constants, scan FSM states and decode result kinds.
// Patterns are {a,b,c,d,e,f,g}, active low, bit 6 = a.
package seg_scan_decoder_pkg;

   typedef enum logic [1:0] {IDLE, TRACK, HOLD} scan_state_t;
   typedef enum logic [1:0] {HEX, BLANK, BAD} seg_kind_t;

   localparam int CNT_W = 8;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [6:0] SEG_HEX [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   // Encoder side of the same table, so encoder and decoder cannot diverge.
   function automatic logic [6:0] seg_encode(input logic [3:0] nib);
      return SEG_HEX[nib];
   endfunction

endpackage

// File: rtl/seg_scan_decoder_decode.sv
// Combinational inverse of the hex-to-segment table: seg_n -> {kind, value}.
module seg_pattern_decode
   import seg_scan_decoder_pkg::*;
(
   input  logic [6:0] seg_n,
   output logic [1:0] kind,
   output logic [3:0] val
);

   always_comb begin
      kind = BAD;
      val  = 4'd0;
      if (seg_n == SEG_BLANK) begin
         kind = BLANK;
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (seg_n == SEG_HEX[i]) begin
               kind = HEX;
               val  = 4'(i);
            end
         end
      end
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Multiplexed seven-segment bus monitor: recovers per-digit hex values.
// Optional decimal-point capture is enabled by defining SEG_SCAN_DP_EN.
//
// state | meaning
// IDLE  | sample has no anode or several anodes low; counter held at 0
// TRACK | counting consecutive identical one-hot samples
// HOLD  | captured; waiting for the sample to change
module seg_scan_decoder
   import seg_scan_decoder_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              seg_n,
   input  logic [NUM_DIGITS-1:0]   an_n,
   input  logic                    clear,
`ifdef SEG_SCAN_DP_EN
   input  logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   dp,
`endif
   output logic [4*NUM_DIGITS-1:0] value,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic [NUM_DIGITS-1:0]   bad_pattern,
   output logic                    frame_done
);

   logic [6:0]            seg_q, seg_p;
   logic [NUM_DIGITS-1:0] an_q, an_p;
   logic [NUM_DIGITS-1:0] sel;
   logic [NUM_DIGITS-1:0] seen;
   logic                  same, onehot, capture;
   scan_state_t           state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [1:0]            kind_raw;
   seg_kind_t             dec_kind;
   logic [3:0]            dec_val;

`ifdef SEG_SCAN_DP_EN
   logic dp_q, dp_p;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dp_q <= 1'b1;
         dp_p <= 1'b1;
      end else begin
         dp_q <= dp_n;
         dp_p <= dp_q;
      end
   end

   assign same = (seg_q == seg_p) && (an_q == an_p) && (dp_q == dp_p);
`else
   assign same = (seg_q == seg_p) && (an_q == an_p);
`endif

   // Second stage holds the previous sample for the stability compare.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_q <= '1;
         an_q  <= '1;
         seg_p <= '1;
         an_p  <= '1;
      end else begin
         seg_q <= seg_n;
         an_q  <= an_n;
         seg_p <= seg_q;
         an_p  <= an_q;
      end
   end

   assign sel    = ~an_q;
   assign onehot = $onehot(sel);

   seg_pattern_decode u_decode (
      .seg_n (seg_q),
      .kind  (kind_raw),
      .val   (dec_val)
   );

   assign dec_kind = seg_kind_t'(kind_raw);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE: begin
            state_nxt = onehot ? TRACK : IDLE;
            cnt_nxt   = onehot ? CNT_W'(1) : '0;
         end
         TRACK, HOLD: begin
            if (same) begin
               cnt_nxt = (state == TRACK) ? cnt + CNT_W'(1) : '0;
            end else begin
               state_nxt = onehot ? TRACK : IDLE;
               cnt_nxt   = onehot ? CNT_W'(1) : '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
      // Counter only ever equals STABLE_CYCLES on the capture edge.
      if (state_nxt == TRACK && cnt_nxt == CNT_W'(STABLE_CYCLES))
         state_nxt = HOLD;
      if (clear) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end
   end

   always_comb begin
      capture = (state_nxt == HOLD) && (cnt_nxt == CNT_W'(STABLE_CYCLES));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value       <= '0;
         digit_valid <= '0;
         bad_pattern <= '0;
         seen        <= '0;
         frame_done  <= 1'b0;
`ifdef SEG_SCAN_DP_EN
         dp          <= '0;
`endif
      end else if (clear) begin
         value       <= '0;
         digit_valid <= '0;
         bad_pattern <= '0;
         seen        <= '0;
         frame_done  <= 1'b0;
`ifdef SEG_SCAN_DP_EN
         dp          <= '0;
`endif
      end else begin
         frame_done <= 1'b0;
         if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (sel[i]) begin
`ifdef SEG_SCAN_DP_EN
                  dp[i] <= ~dp_q;
`endif
                  case (dec_kind)
                     HEX: begin
                        value[4*i +: 4] <= dec_val;
                        digit_valid[i]  <= 1'b1;
                     end
                     BLANK: begin
                        value[4*i +: 4] <= 4'd0;
                        digit_valid[i]  <= 1'b0;
                     end
                     default: bad_pattern[i] <= 1'b1;
                  endcase
               end
            end
            if (&(seen | sel)) begin
               frame_done <= 1'b1;
               seen       <= '0;
            end else begin
               seen <= seen | sel;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed-vector bench for seg_scan_decoder (default build, 4 digits, 3 stable cycles).
module tb_seg_scan_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg_n;
   logic [3:0]  an_n;
   logic        clear;
   logic [15:0] value;
   logic [3:0]  digit_valid;
   logic [3:0]  bad_pattern;
   logic        frame_done;

   int vectors = 0;
   int miscompares = 0;

   seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg_n       (seg_n),
      .an_n        (an_n),
      .clear       (clear),
      .value       (value),
      .digit_valid (digit_valid),
      .bad_pattern (bad_pattern),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
      an_n  = an;
      seg_n = seg;
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; clear = 1'b0; seg_n = 7'h7F; an_n = 4'hF;
      #12;
      rst = 1'b0;
      tick();
      vectors++;
      if (value !== 16'h0 || digit_valid !== 4'h0 || bad_pattern !== 4'h0 || frame_done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset: value=%h valid=%b bad=%b fd=%b, want 0", value, digit_valid, bad_pattern, frame_done);
      end
   endtask

   task automatic test_basic_capture();
      hold(4'b1110, 7'b0010010, 3);
      vectors++;
      if (digit_valid !== 4'b0000) begin
         miscompares++;
         $display("FAIL basic_early: valid=%b want 0000 after edge 3", digit_valid);
      end
      hold(4'b1111, 7'h7F, 1);
      vectors++;
      if (value[3:0] !== 4'd2 || digit_valid !== 4'b0001) begin
         miscompares++;
         $display("FAIL basic_capture: value=%h valid=%b want 2 / 0001", value[3:0], digit_valid);
      end
      hold(4'b1111, 7'h7F, 2);
   endtask

   task automatic test_short_pulse();
      hold(4'b1101, 7'b0000100, 2);
      hold(4'b1111, 7'h7F, 5);
      vectors++;
      if (digit_valid[1] !== 1'b0 || value[7:4] !== 4'd0) begin
         miscompares++;
         $display("FAIL short_pulse: valid1=%b value1=%h want 0/0", digit_valid[1], value[7:4]);
      end
   endtask

   task automatic test_decode_table();
      logic [6:0] pats [17] = '{
         7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
         7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
         7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
         7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000,
         7'b1111111
      };
      for (int p = 0; p < 17; p++) begin
         hold(4'b1110, pats[p], 3);
         hold(4'b1111, 7'h7F, 2);
         vectors++;
         if (p < 16) begin
            if (value[3:0] !== 4'(p) || digit_valid[0] !== 1'b1 || bad_pattern[0] !== 1'b0) begin
               miscompares++;
               $display("FAIL decode_%0d: value=%h valid=%b bad=%b want %h/1/0", p, value[3:0], digit_valid[0], bad_pattern[0], 4'(p));
            end
         end else begin
            if (value[3:0] !== 4'd0 || digit_valid[0] !== 1'b0 || bad_pattern[0] !== 1'b0) begin
               miscompares++;
               $display("FAIL decode_blank: value=%h valid=%b bad=%b want 0/0/0", value[3:0], digit_valid[0], bad_pattern[0]);
            end
         end
      end
      do_clear();
   endtask

   task automatic scan(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                       input logic [6:0] p3, input logic [3:0] mask, input logic expect_pulse,
                       input string name);
      logic [6:0] pats [4];
      logic       exp;
      int         pulses;
      pats = '{p0, p1, p2, p3};
      pulses = 0;
      for (int d = 0; d < 4; d++) begin
         if (mask[d]) begin
            an_n  = ~(4'b0001 << d);
            seg_n = pats[d];
            for (int t = 0; t < 4; t++) begin
               tick();
               exp = expect_pulse && d == 3 && t == 3;
               if (frame_done === 1'b1) pulses++;
               vectors++;
               if (frame_done !== exp) begin
                  miscompares++;
                  $display("FAIL %s_fd d%0d t%0d: frame_done=%b want %b", name, d, t, frame_done, exp);
               end
            end
         end
      end
      hold(4'b1111, 7'h7F, 2);
      vectors++;
      if (pulses !== (expect_pulse ? 1 : 0)) begin
         miscompares++;
         $display("FAIL %s_pulses: got %0d want %0d", name, pulses, expect_pulse ? 1 : 0);
      end
   endtask

   task automatic test_full_scan();
      do_clear();
      scan(7'b1001111, 7'b1100000, 7'b0111000, 7'b0000000, 4'hF, 1'b1, "scan1");
      vectors++;
      if (value !== 16'h8FB1 || digit_valid !== 4'hF) begin
         miscompares++;
         $display("FAIL scan_value: value=%h valid=%b want 8fb1/1111", value, digit_valid);
      end
      scan(7'b1001111, 7'b1100000, 7'b0111000, 7'b0000000, 4'hF, 1'b1, "scan2");
   endtask

   task automatic test_bad_pattern();
      hold(4'b1011, 7'b1010101, 4);
      hold(4'b1111, 7'h7F, 2);
      vectors++;
      if (bad_pattern !== 4'b0100 || value[11:8] !== 4'hF || digit_valid[2] !== 1'b1) begin
         miscompares++;
         $display("FAIL bad_flag: bad=%b value2=%h valid2=%b want 0100/f/1", bad_pattern, value[11:8], digit_valid[2]);
      end
      hold(4'b1011, 7'b0100100, 4);
      hold(4'b1111, 7'h7F, 2);
      vectors++;
      if (bad_pattern !== 4'b0100 || value[11:8] !== 4'd5) begin
         miscompares++;
         $display("FAIL bad_sticky: bad=%b value2=%h want 0100/5", bad_pattern, value[11:8]);
      end
      do_clear();
      vectors++;
      if (bad_pattern !== 4'h0 || value !== 16'h0 || digit_valid !== 4'h0) begin
         miscompares++;
         $display("FAIL bad_clear: bad=%b value=%h valid=%b want 0", bad_pattern, value, digit_valid);
      end
   endtask

   task automatic test_overlap();
      hold(4'b1100, 7'b0000110, 5);
      vectors++;
      if (digit_valid !== 4'h0 || value !== 16'h0 || bad_pattern !== 4'h0) begin
         miscompares++;
         $display("FAIL overlap: valid=%b value=%h bad=%b want 0", digit_valid, value, bad_pattern);
      end
      hold(4'b1110, 7'b0000110, 3);
      vectors++;
      if (digit_valid !== 4'h0) begin
         miscompares++;
         $display("FAIL overlap_early: valid=%b want 0000", digit_valid);
      end
      hold(4'b1111, 7'h7F, 1);
      vectors++;
      if (value[3:0] !== 4'd3 || digit_valid !== 4'b0001) begin
         miscompares++;
         $display("FAIL overlap_capture: value0=%h valid=%b want 3/0001", value[3:0], digit_valid);
      end
      hold(4'b1111, 7'h7F, 2);
   endtask

   task automatic test_clear_on_capture();
      do_clear();
      scan(7'h7F, 7'b0010010, 7'b0000110, 7'b1001100, 4'b1110, 1'b0, "pre");
      hold(4'b1110, 7'b0000000, 3);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      vectors++;
      if (value !== 16'h0 || digit_valid !== 4'h0 || frame_done !== 1'b0) begin
         miscompares++;
         $display("FAIL clear_capture: value=%h valid=%b fd=%b want 0", value, digit_valid, frame_done);
      end
      hold(4'b1111, 7'h7F, 2);
      vectors++;
      if (digit_valid !== 4'h0 || frame_done !== 1'b0) begin
         miscompares++;
         $display("FAIL clear_after: valid=%b fd=%b want 0", digit_valid, frame_done);
      end
      scan(7'b0000001, 7'b1001111, 7'b0010010, 7'h7F, 4'b0111, 1'b0, "post");
      vectors++;
      if (digit_valid !== 4'b0111 || value !== 16'h0210) begin
         miscompares++;
         $display("FAIL clear_rescan: valid=%b value=%h want 0111/0210", digit_valid, value);
      end
   endtask

   task automatic test_reset_mid_track();
      hold(4'b0111, 7'b0100000, 2);
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if (value !== 16'h0 || digit_valid !== 4'h0 || bad_pattern !== 4'h0 || frame_done !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_async: value=%h valid=%b bad=%b fd=%b want 0", value, digit_valid, bad_pattern, frame_done);
      end
      #3;
      rst = 1'b0;
      hold(4'b0111, 7'b0100000, 3);
      vectors++;
      if (digit_valid !== 4'h0) begin
         miscompares++;
         $display("FAIL rst_partial: valid=%b want 0000", digit_valid);
      end
      tick();
      vectors++;
      if (digit_valid !== 4'b1000 || value[15:12] !== 4'd6) begin
         miscompares++;
         $display("FAIL rst_recapture: valid=%b value3=%h want 1000/6", digit_valid, value[15:12]);
      end
   endtask

   initial begin
      test_reset();
      test_basic_capture();
      test_short_pulse();
      test_decode_table();
      test_full_scan();
      test_bad_pattern();
      test_overlap();
      test_clear_on_capture();
      test_reset_mid_track();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Reads a multiplexed, active-low seven-segment display bus (segments a..g plus anode scan lines) and recovers the 4-bit hex value shown on each digit.
- It is the inverse of the hex-to-segment encoder. It serves as a display monitor and loopback checker, and lets test logic read back what the display drivers show.
- Each digit's pattern must be stable for a qualifying interval before it is captured.
- Unknown patterns are flagged, not decoded.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits, one active-low anode line each.
- STABLE_CYCLES, 3: consecutive identical samples required before capture; legal range 1..255.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- seg_n, input, 7: segments {a,b,c,d,e,f,g}, active low; bit 6 = a.
- an_n, input, NUM_DIGITS: anode scan, active low; exactly one low selects that digit.
- clear, input, 1: synchronous clear of captured state.
- value, output, 4*NUM_DIGITS: decoded digits; digit i occupies bits [4i+3:4i].
- digit_valid, output, NUM_DIGITS: digit i holds a valid decoded value.
- bad_pattern, output, NUM_DIGITS: sticky flag; an undecodable pattern was captured on digit i.
- frame_done, output, 1: one-cycle pulse when every digit has been captured since the last pulse, reset or clear.

Behaviour:
- Reset state: value=0, digit_valid=0, bad_pattern=0, frame_done=0, seen mask=0, FSM=IDLE, counter=0, sample registers=all ones.
- Input stage: seg_n and an_n are registered once per clock into sample registers; all decision logic uses the registered samples.
- Decode table, {a..g} active low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - 1111111 = blank.
  - Any other pattern = bad.
- FSM IDLE: the sample has zero or more than one anode low. Counter is held at 0.
  - Go to TRACK with counter=1 when exactly one anode is low.
- FSM TRACK: the sample equals the previous sample (same anode, same segments). Counter increments.
  - Any difference: restart TRACK with counter=1 if one-hot, otherwise go to IDLE.
  - When the counter reaches STABLE_CYCLES, capture on that edge and go to HOLD.
- FSM HOLD: no further capture while the sample is unchanged.
  - Any change: go to TRACK (one-hot, counter=1) or IDLE.
- Capture to digit i:
  - Hex pattern: value[i]=decoded value, digit_valid[i]=1.
  - Blank: value[i]=0, digit_valid[i]=0.
  - Bad pattern: value[i] is unchanged and bad_pattern[i] is set (sticky until clear or rst). digit_valid[i] is unchanged.
  - In all three cases, seen[i] is set.
- Latency: with a pattern present before edges 1..S (S=STABLE_CYCLES), outputs update after edge S+1.
- frame_done:
  - Asserts for one cycle on the edge where the seen mask would become all ones.
  - On that edge the mask clears, with the capturing digit's bit included in the clear.
  - Recapturing an already-seen digit has no effect on the mask.
- clear:
  - Zeros value, digit_valid, bad_pattern and the seen mask.
  - Suppresses frame_done.
  - Forces the FSM to IDLE.
  - clear wins over a capture on the same edge.
- rst asserted mid-track: immediate return to the reset state; a partial count is discarded.
- An anode overlap or gap during scan transitions resets qualification; it never causes a capture.

Optional Feature:
- Macro: SEG_SCAN_DP_EN.
- When defined:
  - Adds input dp_n (1, active low) and output dp (NUM_DIGITS).
  - dp_n is sampled with seg_n and is part of the stability comparison.
  - dp[i] is updated on every capture of digit i, including blank and bad.
  - dp is cleared by rst and clear.
- When undefined: no dp ports and no dp logic; behaviour is as above.

Decomposition:
- Shared package: seven-segment pattern constants (16 hex codes plus BLANK), the FSM state enum {IDLE, TRACK, HOLD}, and decode result kind {HEX, BLANK, BAD}.
- One sub-module, seg_pattern_decode:
  - Purely combinational.
  - Maps seg_n[6:0] to {kind, value[3:0]}.
  - Shares constants with the encoder so the two tables cannot diverge.

Test Plan:
- Basic capture: an_n=1110, seg_n=0010010 held for 3 clocks → value[3:0]=2 and digit_valid[0]=1 after edge 4; no change at edge 3.
- Short pulse rejected: an_n=1101, seg_n=0000100 held only 2 clocks, then an_n=1111 → digit 1 is not captured and digit_valid[1] stays 0.
- Full scan of digits 0..3 showing 1, b, F, 8 (4 cycles each) → value=16'h8Fb1 and frame_done pulses exactly once, on digit 3's capture edge; a second identical scan gives a second pulse.
- Bad pattern: digit 2 with seg_n=1010101 → bad_pattern[2]=1 and value[11:8] unchanged; a later valid 5 updates the value while bad_pattern[2] stays 1 until clear.
- Glitch and overlap: an_n=1100 for 5 cycles → no capture, FSM stays IDLE; capture then occurs after 3 clean cycles of 1110.
- clear coincident with a capture edge → all outputs 0, no frame_done; rst asserted mid-TRACK → outputs 0 asynchronously.
